// File: rtl/stage_execute.sv
// stage_execute: execute stage of the RV32IM pipeline.
// Selects forwarded operands, computes ALU / MUL results in one cycle, runs a
// 32-step restoring divider for DIV/DIVU/REM/REMU, resolves branches and jumps
// and registers the result towards the memory stage.
//
// Ports
//   clk, rst                    core clock, synchronous active-high reset
//   decode_*                    instruction fields from the decode register
//   forward_a_sel/_b_sel        00/11 regfile, 01 wb_write_data, 10 mem_alu_result
//   mem_alu_result, wb_write_data  forwarding sources
//   flush                       squash the instruction currently in execute
//   stall                       hold fetch/decode while a divide is running
//   pc_src, pc_target           fetch redirect (combinational)
//   execute_*                   registered outputs to the memory stage
//
// Divider FSM
//   state  | meaning
//   IDLE   | no divide in flight; single-cycle ops pass straight through
//   DIV    | one restoring step per cycle, 32 cycles, upstream stalled
//   DONE   | sign fix applied, divide result registers at this edge
module stage_execute #(
  parameter int XLEN      = 32,
  parameter int DIV_STEPS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            decode_valid,
  input  logic [XLEN-1:0] decode_rs1_data,
  input  logic [XLEN-1:0] decode_rs2_data,
  input  logic [XLEN-1:0] decode_imm,
  input  logic [XLEN-1:0] decode_instr_addr,
  input  logic [XLEN-1:0] decode_instr_addr_plus,
  input  logic [4:0]      decode_rd,
  input  logic            decode_regfile_wr_enable,
  input  logic            decode_datamem_wr_enable,
  input  logic [1:0]      decode_result_src,
  input  logic [2:0]      decode_funct3,
  input  logic [3:0]      decode_alu_control,
  input  logic            decode_alu_src,
  input  logic            decode_muldiv,
  input  logic            decode_branch,
  input  logic            decode_jump,
  input  logic            decode_jalr,
  input  logic [1:0]      forward_a_sel,
  input  logic [1:0]      forward_b_sel,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] wb_write_data,
  input  logic            flush,
  output logic            stall,
  output logic            pc_src,
  output logic [XLEN-1:0] pc_target,
  output logic [4:0]      execute_rd,
  output logic            execute_regfile_wr_enable,
  output logic            execute_datamem_wr_enable,
  output logic [XLEN-1:0] execute_alu_result,
  output logic [XLEN-1:0] execute_wr_datamem_data,
  output logic [XLEN-1:0] execute_instr_addr_plus,
  output logic [1:0]      execute_result_src,
  output logic [2:0]      execute_funct3
);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] fa, fb, op_a, op_b;
  logic [XLEN-1:0] alu_res, mul_res, single_res, div_res, result_d;
  logic [63:0]     mul_p;
  logic            mul_a_s, mul_b_s;
  logic            taken, is_div, start, bubble;

  // divider datapath; dvd_q shifts the dividend out and the quotient in
  logic [4:0]      count_q;
  logic [XLEN-1:0] dvd_q, rem_q, dsr_q;
  logic            q_neg_q, r_neg_q, div0_q, ovf_q, sel_rem_q;
  logic [XLEN:0]   rem_sh;
  logic            step_ge;
  logic [XLEN-1:0] rem_nxt, q_fix, r_fix;
  logic            div_signed, a_neg, b_neg;

  always_comb begin
    case (forward_a_sel)
      2'b01:   fa = wb_write_data;
      2'b10:   fa = mem_alu_result;
      default: fa = decode_rs1_data;
    endcase
    case (forward_b_sel)
      2'b01:   fb = wb_write_data;
      2'b10:   fb = mem_alu_result;
      default: fb = decode_rs2_data;
    endcase
  end

  assign op_a = fa;
  assign op_b = decode_alu_src ? decode_imm : fb;

  always_comb begin
    case (decode_alu_control)
      4'd0:    alu_res = op_a + op_b;
      4'd1:    alu_res = op_a - op_b;
      4'd2:    alu_res = op_a << op_b[4:0];
      4'd3:    alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
      4'd4:    alu_res = {31'b0, op_a < op_b};
      4'd5:    alu_res = op_a ^ op_b;
      4'd6:    alu_res = op_a >> op_b[4:0];
      4'd7:    alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
      4'd8:    alu_res = op_a | op_b;
      4'd9:    alu_res = op_a & op_b;
      4'd10:   alu_res = op_b;
      4'd11:   alu_res = decode_instr_addr + op_b;
      default: alu_res = '0;
    endcase
  end

  // 64-bit product of sign- or zero-extended operands; the low 64 bits of the
  // unsigned product equal the signed product modulo 2^64.
  assign mul_a_s = op_a[31] & (decode_funct3[1:0] == 2'b01 || decode_funct3[1:0] == 2'b10);
  assign mul_b_s = op_b[31] & (decode_funct3[1:0] == 2'b01);
  assign mul_p   = {{32{mul_a_s}}, op_a} * {{32{mul_b_s}}, op_b};
  assign mul_res = (decode_funct3[1:0] == 2'b00) ? mul_p[31:0] : mul_p[63:32];

  assign single_res = decode_muldiv ? mul_res : alu_res;

  always_comb begin
    case (decode_funct3)
      3'b000:  taken = (fa == fb);
      3'b001:  taken = (fa != fb);
      3'b100:  taken = ($signed(fa) < $signed(fb));
      3'b101:  taken = ($signed(fa) >= $signed(fb));
      3'b110:  taken = (fa < fb);
      3'b111:  taken = (fa >= fb);
      default: taken = 1'b0;
    endcase
  end

  assign is_div = decode_muldiv & decode_funct3[2];
  assign start  = !rst && state_q == S_IDLE && decode_valid && is_div && !flush;

  // flush beats the stall so a squashed divide releases upstream immediately
  assign stall  = start | (!rst && state_q == S_DIV && !flush);
  assign bubble = stall | flush | !decode_valid;

  assign pc_src    = !rst & decode_valid & !stall & !flush & (decode_jump | (decode_branch & taken));
  assign pc_target = decode_jalr ? ((fa + decode_imm) & ~32'd1) : (decode_instr_addr + decode_imm);

  assign div_signed = !decode_funct3[0];
  assign a_neg      = div_signed & op_a[31];
  assign b_neg      = div_signed & op_b[31];

  // remainder after each step stays below the divisor, so 32 bits hold it
  assign rem_sh  = {rem_q, dvd_q[31]};
  assign step_ge = (rem_sh >= {1'b0, dsr_q});
  assign rem_nxt = step_ge ? (rem_sh[31:0] - dsr_q) : rem_sh[31:0];

  assign q_fix = q_neg_q ? (32'd0 - dvd_q) : dvd_q;
  assign r_fix = r_neg_q ? (32'd0 - rem_q) : rem_q;

  always_comb begin
    div_res = sel_rem_q ? r_fix : q_fix;
    if (div0_q) begin
      div_res = sel_rem_q ? r_fix : 32'hFFFF_FFFF;
    end else if (ovf_q) begin
      div_res = sel_rem_q ? 32'd0 : 32'h8000_0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_DIV;
      S_DIV: begin
        if (flush)                                  state_d = S_IDLE;
        else if (count_q == 5'(DIV_STEPS - 1))      state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    result_d = (state_q == S_DONE) ? div_res : single_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      dvd_q     <= '0;
      rem_q     <= '0;
      dsr_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      sel_rem_q <= 1'b0;
    end else if (start) begin
      count_q   <= '0;
      dvd_q     <= a_neg ? (32'd0 - op_a) : op_a;
      dsr_q     <= b_neg ? (32'd0 - op_b) : op_b;
      rem_q     <= '0;
      q_neg_q   <= a_neg ^ b_neg;
      r_neg_q   <= a_neg;
      div0_q    <= (op_b == 32'd0);
      ovf_q     <= div_signed && op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF;
      sel_rem_q <= decode_funct3[1];
    end else if (state_q == S_DIV) begin
      count_q <= count_q + 5'd1;
      dvd_q   <= {dvd_q[30:0], step_ge};
      rem_q   <= rem_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      execute_rd                <= '0;
      execute_regfile_wr_enable <= 1'b0;
      execute_datamem_wr_enable <= 1'b0;
      execute_alu_result        <= '0;
      execute_wr_datamem_data   <= '0;
      execute_instr_addr_plus   <= '0;
      execute_result_src        <= '0;
      execute_funct3            <= '0;
    end else begin
      execute_rd                <= bubble ? 5'd0 : decode_rd;
      execute_regfile_wr_enable <= !bubble & decode_regfile_wr_enable;
      execute_datamem_wr_enable <= !bubble & decode_datamem_wr_enable;
      execute_alu_result        <= result_d;
      execute_wr_datamem_data   <= fb;
      execute_instr_addr_plus   <= decode_instr_addr_plus;
      execute_result_src        <= decode_result_src;
      execute_funct3            <= decode_funct3;
    end
  end

endmodule
